// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline-side and memory-side signals of the MEM-stage access controller
// master: the pipeline/memory environment; slave: the controller itself.
interface mem_access_ctrl_if;
  logic [3:0]  M;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_out;
  logic        stall;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport master (
    output M, addr, wdata, mem_rdata, mem_ack,
    input  rdata_out, stall, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport slave (
    input  M, addr, wdata, mem_rdata, mem_ack,
    output rdata_out, stall, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store controller with single-request memory handshake and timeout
// Ports: clk (rising edge), rst (async, active-high), bus (slave modport):
//   M/addr/wdata in, rdata_out/stall/err out on the pipeline side;
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata out, mem_rdata/mem_ack in on the memory side.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d, we_q, we_d, byte_q, byte_d, to_q, to_d;
  logic [1:0]    off_q, off_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   maddr_q, maddr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]    rd, wr;
  logic          ok, word, mis, go, bad;
  logic [7:0]    lane;
  assign rd   = bus.M[3:2];
  assign wr   = bus.M[1:0];
  assign ok   = ((rd == 2'b00) != (wr == 2'b00)) && rd != 2'b11 && wr != 2'b11;
  assign word = rd == 2'b01 || wr == 2'b01;
  assign mis  = word && bus.addr[1:0] != 2'b00;
  assign go   = ok && !mis;
  assign bad  = bus.M != 4'b0000 && !go;
  assign lane = 8'(bus.mem_rdata >> {off_q, 3'b000});
  // stall and the IDLE error pulse are combinational on M, so reset must mask them explicitly
  assign bus.stall     = !rst && (state_q == BUSY || (state_q == IDLE && go));
  assign bus.err       = !rst && ((state_q == IDLE && bad) || to_q);
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata_out = rdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    req_d   = 1'b0;
    to_d    = 1'b0;
    we_d    = we_q;
    byte_d  = byte_q;
    off_d   = off_q;
    be_d    = be_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = BUSY;
        req_d   = 1'b1;
        we_d    = wr != 2'b00;
        byte_d  = !word;
        off_d   = bus.addr[1:0];
        maddr_d = {bus.addr[31:2], 2'b00};
        be_d    = word ? 4'b1111 : 4'b0001 << bus.addr[1:0];
        wdata_d = word ? bus.wdata : {4{bus.wdata[7:0]}};
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        req_d = 1'b1;
        if (bus.mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = we_q ? rdata_q : byte_q ? {{24{lane[7]}}, lane} : bus.mem_rdata;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          to_d    = 1'b1;
          rdata_d = we_q ? rdata_q : 32'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      to_q    <= 1'b0;
      off_q   <= 2'b00;
      be_q    <= 4'b0000;
      maddr_q <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      to_q    <= to_d;
      off_q   <= off_d;
      be_q    <= be_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
endmodule
